// File: rtl/imm_encoder_if.sv
// Request/response bundle for the immediate encoder: encode requests in,
// packed instruction words out, plus error status.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        imm_src;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_clr;
    logic        range_err;
    logic [7:0]  err_count;

    modport master (
        output in_valid, imm_src, imm, opcode, funct3, rd, rs1, rs2,
        output out_ready, err_clr,
        input  in_ready, out_valid, out_instr, out_addr, range_err, err_count
    );

    modport slave (
        input  in_valid, imm_src, imm, opcode, funct3, rd, rs1, rs2,
        input  out_ready, err_clr,
        output in_ready, out_valid, out_instr, out_addr, range_err, err_count
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 12-bit immediate into I- or S-type RISC-V words, tags each with a
// sequential byte address and buffers them in a 2-entry registered FIFO.
module imm_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    imm_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e      state_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] head_instr_q;
    logic [31:0] head_addr_q;
    logic [31:0] tail_instr_q;
    logic [31:0] tail_addr_q;
    logic [31:0] addr_q, addr_d;
    logic        range_err_q, range_err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        range_ok;
    logic        accept;
    logic        push;
    logic        fail;
    logic        pop;
    logic [31:0] enc_instr;

    // Immediate fits in 12 signed bits iff the upper 21 bits are all copies of bit 11.
    assign range_ok = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);

    assign enc_instr = bus.imm_src
        ? {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode}
        : {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};

    assign accept = bus.in_valid & in_ready_q;
    assign push   = accept & range_ok;
    assign fail   = accept & ~range_ok;
    assign pop    = out_valid_q & bus.out_ready;

    // Head entry is the output register; tail holds the second word when FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            head_instr_q <= '0;
            head_addr_q  <= BASE_ADDR;
        end else begin
            in_ready_q <= 1'b1;
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_instr_q <= enc_instr;
                        head_addr_q  <= addr_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_instr_q <= enc_instr;
                        head_addr_q  <= addr_q;
                    end else if (push) begin
                        // NOTE: tail storage is never reset; FSM state alone says whether it is live.
                        tail_instr_q <= enc_instr;
                        tail_addr_q  <= addr_q;
                        in_ready_q   <= 1'b0;
                        state_q      <= FULL;
                    end else if (pop) begin
                        head_instr_q <= '0;
                        out_valid_q  <= 1'b0;
                        state_q      <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_instr_q <= tail_instr_q;
                        head_addr_q  <= tail_addr_q;
                        state_q      <= ONE;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        addr_d      = addr_q;
        range_err_d = range_err_q;
        err_count_d = err_count_q;
        if (push) begin
            addr_d = addr_q + 32'd4;
        end
        // A clear coincident with a failure leaves exactly that one failure recorded.
        if (bus.err_clr) begin
            range_err_d = fail;
            err_count_d = {7'd0, fail};
        end else if (fail) begin
            range_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= BASE_ADDR;
            range_err_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            addr_q      <= addr_d;
            range_err_q <= range_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = head_instr_q;
    assign bus.out_addr  = head_addr_q;
    assign bus.range_err = range_err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, the address assigned to the first emitted instruction.
REQ-002 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  encode request valid.
REQ-005 The block SHALL have port in_ready  output  1  request accepted when in_valid&in_ready.
REQ-006 The block SHALL have port imm_src  input  1  1=S-type, 0=I-type.
REQ-007 The block SHALL have port imm  input  32  sign-extended immediate to pack.
REQ-008 The block SHALL have ports opcode  input  7, funct3  input  3, rd  input  5, rs1  input  5, rs2  input  5  instruction fields.
REQ-009 The block SHALL have port out_valid  output  1  encoded word valid.
REQ-010 The block SHALL have port out_ready  input  1  word consumed when out_valid&out_ready.
REQ-011 The block SHALL have ports out_instr  output  32 and out_addr  output  32  encoded word and its byte address.
REQ-012 The block SHALL have port err_clr  input  1  clears error status.
REQ-013 The block SHALL have ports range_err  output  1  sticky error flag, and err_count  output  8  saturating error count.

Function
REQ-014 Range check SHALL pass iff imm[31:11] are all equal (signed range -2048..2047).
REQ-015 I-type encoding SHALL be {imm[11:0], rs1, funct3, rd, opcode}; rs2 ignored.
REQ-016 S-type encoding SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rd ignored.
REQ-017 Round trip: I/S decode sign-extension of out_instr SHALL reproduce imm for every in-range request.
REQ-018 Passing requests SHALL enter a 2-entry FIFO; output registered, latency 1 cycle (accept at edge k -> out_valid after edge k).
REQ-019 FIFO occupancy states EMPTY/ONE/FULL; push only -> up, pop only -> down, push+pop in ONE -> stays ONE.
REQ-020 in_ready SHALL be a registered signal equal to (state != FULL) and not in reset.
REQ-021 While out_valid=1 and out_ready=0, out_instr/out_addr SHALL hold stable; words emitted in acceptance order.
REQ-022 out_addr SHALL be BASE_ADDR + 4*n, n = count of previously enqueued words, assigned at enqueue; wraps modulo 2^32.
REQ-023 A failing request SHALL be consumed (handshake completes), not enqueued, not advance the address, set range_err, increment err_count saturating at 255.
REQ-024 err_clr SHALL clear range_err and err_count next cycle; err_clr coincident with a failing request SHALL yield range_err=1, err_count=1.
REQ-025 When state=EMPTY, out_valid SHALL be 0 and out_instr SHALL be 0.

Reset
REQ-026 With rst=1 at an edge: FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, in_ready=0, range_err=0, err_count=0, address counter=BASE_ADDR.
REQ-027 Reset mid-operation SHALL discard all buffered words; in_ready=1 on the first edge after rst deasserts.

Verification
REQ-028 I-type: imm=32'hFFFF_FFFF, rs1=6, rd=5, funct3=0, opcode=7'h13, imm_src=0 -> out_instr=32'hFFF3_0293, out_addr=0, one cycle later.
REQ-029 S-type: imm=8, rs2=7, rs1=2, funct3=2, opcode=7'h23, imm_src=1 -> out_instr=32'h0071_2423; next word out_addr=4.
REQ-030 Range error: imm=2048 -> no out_valid, range_err=1, err_count=1; following valid request gets unadvanced address.
REQ-031 Backpressure: out_ready=0, three back-to-back requests -> in_ready=0 after two accepted, third held; out_ready=1 -> three words in order, addresses 0,4,8.
REQ-032 err_clr with a simultaneous failing request -> range_err=1, err_count=1; 256 failures -> err_count=255.
REQ-033 rst asserted with FIFO FULL -> out_valid=0 next cycle, next word out_addr=BASE_ADDR.
